// File: rtl/falu_arbiter.sv
// falu_arbiter: round-robin sharing of one combinational FALU between NUM_REQ requesters.
// Optional FALU_ZERO_SHORTCUT_EN answers requests with a +/-0 operand without using the FALU.
module falu_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_rs1,
    input  logic [32*NUM_REQ-1:0] req_rs2,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [31:0]           falu_rs1,
    output logic [31:0]           falu_rs2,
    output logic                  falu_ctrl,
    input  logic [31:0]           falu_out,
    output logic                  busy
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t         state;
    logic [IW-1:0]  rr_ptr, owner, g, c;
    logic           found, gs, sc_hit;
    logic [31:0]    ga, gb, sc_data;
    // Walk offsets downward so the candidate closest to rr_ptr wins.
    always_comb begin
        g = rr_ptr;
        c = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[c]) begin
                g = c;
                found = 1'b1;
            end
        end
    end
    assign ga        = req_rs1[32*g +: 32];
    assign gb        = req_rs2[32*g +: 32];
    assign gs        = req_sub[g];
    assign req_ready = (state == IDLE && found) ? NUM_REQ'(1) << g : '0;
    assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << owner : '0;
    assign busy      = state != IDLE;
`ifdef FALU_ZERO_SHORTCUT_EN
    logic za, zb;
    assign za      = ga[30:0] == 31'd0;
    assign zb      = gb[30:0] == 31'd0;
    assign sc_hit  = za | zb;
    assign sc_data = (zb && !za) ? ga :
                     (za && !zb) ? {gb[31] ^ gs, gb[30:0]} :
                     {ga[31] & (gb[31] ^ gs), 31'd0};
`else
    assign sc_hit  = 1'b0;
    assign sc_data = 32'd0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            falu_rs1  <= '0;
            falu_rs2  <= '0;
            falu_ctrl <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    owner  <= g;
                    rr_ptr <= IW'((int'(g) + 1) % NUM_REQ);
                    state  <= sc_hit ? RESP : EXEC;
                    if (sc_hit) rsp_data <= sc_data;
                    else begin
                        falu_rs1  <= ga;
                        falu_rs2  <= gb;
                        falu_ctrl <= gs;
                    end
                end
                EXEC: begin
                    rsp_data <= falu_out;
                    state    <= RESP;
                end
                RESP: if (rsp_ready[owner]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_falu_arbiter.sv
// tb_falu_arbiter: scoreboard bench for falu_arbiter with a stub FALU on the falu_* pins.
module tb_falu_arbiter;
    localparam int NR = 2;
    typedef struct packed {logic [31:0] a; logic [31:0] b; logic s;} op_t;
    typedef struct {int own; op_t op; logic [31:0] d; int lat; int cyc;} sb_t;
    logic            clk = 1'b0, rst_n = 1'b0;
    logic [NR-1:0]   req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
    logic [32*NR-1:0] req_rs1, req_rs2;
    logic [31:0]     rsp_data, falu_rs1, falu_rs2, falu_out, held;
    logic            falu_ctrl, busy;
    op_t             rq[NR][$];
    sb_t             sb[$];
    int              glog[$];
    int              checks = 0, failures = 0, cyc = 0, acc_idx = -1, hs_cyc = 0, stall = 0;
    bit              hs_wait = 0, prev_rv = 0;

    always #5 clk = ~clk;

    falu_arbiter #(.NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .falu_rs1(falu_rs1), .falu_rs2(falu_rs2), .falu_ctrl(falu_ctrl),
        .falu_out(falu_out), .busy(busy)
    );

    // Stub FALU: exact results for the two reference vectors, integer mix otherwise.
    function automatic logic [31:0] falu_model(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (!s && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (s && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        return s ? a - b : a + b;
    endfunction
    assign falu_out = falu_model(falu_rs1, falu_rs2, falu_ctrl);

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic s);
        op_t o;
        o.a = a; o.b = b; o.s = s;
        return o;
    endfunction

    task automatic expect_of(input op_t o, output logic [31:0] d, output int lat);
        d = falu_model(o.a, o.b, o.s);
        lat = 2;
`ifdef FALU_ZERO_SHORTCUT_EN
        if (o.a[30:0] == 31'd0 || o.b[30:0] == 31'd0) begin
            lat = 1;
            if (o.a[30:0] != 31'd0) d = o.a;
            else if (o.b[30:0] != 31'd0) d = {o.b[31] ^ o.s, o.b[30:0]};
            else d = {o.a[31] & (o.b[31] ^ o.s), 31'd0};
        end
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = rq[i].size() > 0;
            req_rs1[32*i +: 32] = rq[i].size() > 0 ? rq[i][0].a : 32'd0;
            req_rs2[32*i +: 32] = rq[i].size() > 0 ? rq[i][0].b : 32'd0;
            req_sub[i] = rq[i].size() > 0 ? rq[i][0].s : 1'b0;
        end
        rsp_ready = stall > 0 ? '0 : '1;
    endtask

    task automatic monitor();
        sb_t e;
        acc_idx = -1;
        chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
        if (busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
        if (req_ready != '0) begin
            chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++) if (req_ready[i]) acc_idx = i;
            e.own = acc_idx; e.op = rq[acc_idx][0]; e.cyc = cyc;
            expect_of(e.op, e.d, e.lat);
            sb.push_back(e);
            glog.push_back(acc_idx);
            if (hs_wait) chk("next_grant_gap", 32'(cyc - hs_cyc), 32'd1);
            hs_wait = 0;
        end
        if (busy && rsp_valid == '0) begin
            if (sb.size() == 0) chk("exec_without_request", 32'(busy), 32'd0);
            else begin
                chk("exec_falu_rs1", falu_rs1, sb[0].op.a);
                chk("exec_falu_rs2", falu_rs2, sb[0].op.b);
                chk("exec_falu_ctrl", 32'(falu_ctrl), 32'(sb[0].op.s));
            end
        end
        if (rsp_valid != '0) begin
            chk("rsp_onehot", 32'($onehot(rsp_valid)), 32'd1);
            if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            else begin
                if (!prev_rv) begin
                    chk("latency", 32'(cyc - sb[0].cyc), 32'(sb[0].lat));
                    chk("rsp_owner", 32'(rsp_valid), 32'(1) << sb[0].own);
                    chk("rsp_data", rsp_data, sb[0].d);
                    held = rsp_data;
                end else chk("rsp_data_stable", rsp_data, held);
                if ((rsp_valid & rsp_ready) != '0) begin
                    void'(sb.pop_front());
                    hs_cyc = cyc;
                    hs_wait = req_valid != '0;
                end
            end
        end
        prev_rv = (rsp_valid != '0) && ((rsp_valid & rsp_ready) == '0);
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (acc_idx >= 0) void'(rq[acc_idx].pop_front());
        acc_idx = -1;
        if (stall > 0) stall--;
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((sb.size() != 0 || rq[0].size() != 0 || rq[1].size() != 0 || busy) && n < max) begin
            cycle();
            n++;
        end
        if (n >= max) chk("timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_falu_rs1", falu_rs1, 32'd0);
        chk("rst_falu_rs2", falu_rs2, 32'd0);
        chk("rst_falu_ctrl", 32'(falu_ctrl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        rq[0].push_back(mk(32'h3F800000, 32'h40000000, 1'b0));
        run_until_idle(50);
        rq[1].push_back(mk(32'h40400000, 32'h3F800000, 1'b1));
        run_until_idle(50);
        glog.delete();
        for (int k = 0; k < 4; k++) begin
            rq[0].push_back(mk(32'h1000 + 32'(k), 32'h20 * 32'(k + 1), 1'(k)));
            rq[1].push_back(mk(32'h9000 + 32'(k), 32'h7 * 32'(k + 3), 1'(k + 1)));
        end
        run_until_idle(100);
        chk("rr_count", 32'(glog.size()), 32'd8);
        for (int k = 0; k < 8 && k < glog.size(); k++) chk("rr_order", 32'(glog[k]), 32'(k % 2));
        rq[0].push_back(mk(32'hABCD0001, 32'h00001111, 1'b1));
        rq[1].push_back(mk(32'h12340000, 32'h00005678, 1'b0));
        stall = 8;
        run_until_idle(100);
        rq[0].push_back(mk(32'h80000000, 32'h00000000, 1'b1));
        rq[1].push_back(mk(32'h00000000, 32'h3F800000, 1'b1));
        rq[0].push_back(mk(32'h80000000, 32'h80000000, 1'b0));
        for (int k = 0; k < 10; k++) begin
            logic [31:0] a, b;
            a = (k % 4 == 0) ? {k[0], 31'd0} : $urandom;
            b = (k % 3 == 0) ? {k[1], 31'd0} : $urandom;
            rq[$urandom_range(0, 1)].push_back(mk(a, b, 1'($urandom_range(0, 1))));
        end
        run_until_idle(300);
        rq[0].push_back(mk(32'h12345678, 32'h0BADF00D, 1'b0));
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(busy && rsp_valid == '0) && n < 10);
        if (n >= 10) chk("reach_exec", 32'(n), 32'd0);
        rst_n = 1'b0;
        cycle();
        sb.delete();
        prev_rv = 0;
        hs_wait = 0;
        cycle();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        glog.delete();
        rq[1].push_back(mk(32'h00ABCDEF, 32'h00000123, 1'b1));
        rq[0].push_back(mk(32'h00000321, 32'h00FEDCBA, 1'b0));
        run_until_idle(50);
        chk("midrst_first_grant", glog.size() > 0 ? 32'(glog[0]) : 32'hFFFFFFFF, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
